// File: rtl/vlsu_txn_sched.sv
// Vector LSU transaction scheduler: arbitrates load/store address issue under
// per-direction outstanding-burst credits and implements a drain-style fence.
//
// Handshake rule: a transfer happens on the issue port when issue_valid_o and
// issue_ready_i are both 1 at a rising edge; once issue_valid_o is raised it
// stays raised with a stable issue_is_store_o until that transfer happens.
module vlsu_txn_sched #(
  parameter int MaxRdOutstanding = 8,
  parameter int MaxWrOutstanding = 8,
  localparam int MaxOut = (MaxRdOutstanding > MaxWrOutstanding) ?
                          MaxRdOutstanding : MaxWrOutstanding,
  localparam int CntW = $clog2(MaxOut + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ld_req_valid_i,
  output logic            ld_req_ready_o,
  input  logic            st_req_valid_i,
  output logic            st_req_ready_o,
  output logic            issue_valid_o,
  output logic            issue_is_store_o,
  input  logic            issue_ready_i,
  input  logic            r_valid_i,
  input  logic            r_ready_i,
  input  logic            r_last_i,
  input  logic            b_valid_i,
  input  logic            b_ready_i,
  input  logic            fence_req_i,
  output logic            fence_done_o,
  output logic [CntW-1:0] rd_cnt_o,
  output logic [CntW-1:0] wr_cnt_o,
  output logic            idle_o,
  output logic            cnt_err_o
);

  localparam logic [CntW-1:0] RdLimit = CntW'(MaxRdOutstanding);
  localparam logic [CntW-1:0] WrLimit = CntW'(MaxWrOutstanding);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            lock_q, lock_d;
  logic            lock_store_q, lock_store_d;
  logic            prio_store_q, prio_store_d;
  logic            fence_pend_q, fence_pend_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic            cnt_err_q, cnt_err_d;

  logic in_run;
  logic ld_elig, st_elig;
  logic grant_valid, grant_store;
  logic issue_hs, ld_hs, st_hs;
  logic r_dec, b_dec;
  logic rd_underflow, wr_underflow;

  assign in_run  = (state_q == RUN);
  assign ld_elig = ld_req_valid_i & (rd_cnt_q < RdLimit) & in_run;
  assign st_elig = st_req_valid_i & (wr_cnt_q < WrLimit) & in_run;

  // A locked grant overrides eligibility so the issue port never changes mid-stall.
  always_comb begin
    grant_valid = 1'b0;
    grant_store = 1'b0;
    if (lock_q) begin
      grant_valid = 1'b1;
      grant_store = lock_store_q;
    end else if (ld_elig && st_elig) begin
      grant_valid = 1'b1;
      grant_store = prio_store_q;
    end else if (ld_elig || st_elig) begin
      grant_valid = 1'b1;
      grant_store = st_elig;
    end
  end

  assign issue_valid_o    = grant_valid & ~rst_i;
  assign issue_is_store_o = grant_store;
  assign issue_hs         = issue_valid_o & issue_ready_i;
  assign ld_hs            = issue_hs & ~grant_store;
  assign st_hs            = issue_hs & grant_store;
  assign ld_req_ready_o   = ld_hs;
  assign st_req_ready_o   = st_hs;

  assign lock_d       = issue_valid_o & ~issue_ready_i;
  assign lock_store_d = grant_store;
  assign prio_store_d = issue_hs ? ~grant_store : prio_store_q;

  assign r_dec = r_valid_i & r_ready_i & r_last_i;
  assign b_dec = b_valid_i & b_ready_i;

  // Credits: same-cycle issue and completion cancel; a completion at zero
  // saturates and flags an accounting error.
  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    rd_underflow = 1'b0;
    case ({ld_hs, r_dec})
      2'b10: rd_cnt_d = rd_cnt_q + 1'b1;
      2'b01: begin
        if (rd_cnt_q == '0) rd_underflow = 1'b1;
        else                rd_cnt_d = rd_cnt_q - 1'b1;
      end
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    wr_underflow = 1'b0;
    case ({st_hs, b_dec})
      2'b10: wr_cnt_d = wr_cnt_q + 1'b1;
      2'b01: begin
        if (wr_cnt_q == '0) wr_underflow = 1'b1;
        else                wr_cnt_d = wr_cnt_q - 1'b1;
      end
      default: wr_cnt_d = wr_cnt_q;
    endcase
  end

  assign cnt_err_d = cnt_err_q | rd_underflow | wr_underflow;

  // A fence seen while the issue port is stalled waits for that transfer first.
  always_comb begin
    state_d      = state_q;
    fence_pend_d = fence_pend_q;
    case (state_q)
      RUN: begin
        if (fence_req_i || fence_pend_q) begin
          if (lock_d) begin
            fence_pend_d = 1'b1;
          end else begin
            fence_pend_d = 1'b0;
            state_d      = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((rd_cnt_d == '0) && (wr_cnt_d == '0)) state_d = ACK;
      end
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      lock_q       <= 1'b0;
      lock_store_q <= 1'b0;
      prio_store_q <= 1'b0;
      fence_pend_q <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      cnt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      lock_store_q <= lock_store_d;
      prio_store_q <= prio_store_d;
      fence_pend_q <= fence_pend_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

  assign fence_done_o = (state_q == ACK) & ~rst_i;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign cnt_err_o    = cnt_err_q;
  assign idle_o       = in_run & (rd_cnt_q == '0) & (wr_cnt_q == '0) &
                        ~ld_req_valid_i & ~st_req_valid_i;

endmodule

// File: tb/tb_vlsu_txn_sched.sv
// Self-checking bench for vlsu_txn_sched: reset-state vector table, directed
// multi-cycle sequences and a randomized run against a rule-level model.
module tb_vlsu_txn_sched;
  localparam int MaxRd = 8;
  localparam int MaxWr = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ld, st, rdy, rv, rr, rl, bv, br, fence;
  logic          ld_rdy_o, st_rdy_o, iss_v_o, iss_st_o, done_o, idle_o, err_o;
  logic [CW-1:0] rd_o, wr_o;

  vlsu_txn_sched #(.MaxRdOutstanding(MaxRd), .MaxWrOutstanding(MaxWr)) dut (
    .clk_i(clk), .rst_i(rst),
    .ld_req_valid_i(ld), .ld_req_ready_o(ld_rdy_o),
    .st_req_valid_i(st), .st_req_ready_o(st_rdy_o),
    .issue_valid_o(iss_v_o), .issue_is_store_o(iss_st_o), .issue_ready_i(rdy),
    .r_valid_i(rv), .r_ready_i(rr), .r_last_i(rl),
    .b_valid_i(bv), .b_ready_i(br),
    .fence_req_i(fence), .fence_done_o(done_o),
    .rd_cnt_o(rd_o), .wr_cnt_o(wr_o), .idle_o(idle_o), .cnt_err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ld = 0; st = 0; rdy = 0; rv = 0; rr = 0; rl = 0; bv = 0; br = 0; fence = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic set_req(input logic l, input logic s, input logic r);
    ld = l; st = s; rdy = r;
  endtask

  task automatic r_beat(input logic on);
    rv = on; rr = on; rl = on;
  endtask

  task automatic b_beat(input logic on);
    bv = on; br = on;
  endtask

  // ---------------- rule-level reference model ----------------
  int m_rd, m_wr, m_mode;   // m_mode: 0 run, 1 drain, 2 ack
  bit m_err, m_locked, m_lock_st, m_pref_st, m_pend;
  bit mv, ms, mhs;

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_mode = 0;
    m_err = 0; m_locked = 0; m_lock_st = 0; m_pref_st = 0; m_pend = 0;
  endtask

  task automatic model_eval(output logic [14:0] vec);
    bit run, le, se, idl;
    run = (m_mode == 0);
    le  = ld && (m_rd < MaxRd) && run;
    se  = st && (m_wr < MaxWr) && run;
    if (m_locked)      begin mv = 1; ms = m_lock_st; end
    else if (le && se) begin mv = 1; ms = m_pref_st; end
    else               begin mv = le || se; ms = se && !le; end
    if (rst) mv = 0;
    mhs = mv && rdy;
    idl = run && (m_rd == 0) && (m_wr == 0) && !ld && !st;
    vec = {mv, ms, mhs && !ms, mhs && ms, idl, (m_mode == 2) && !rst, m_err,
           4'(m_rd), 4'(m_wr)};
  endtask

  task automatic model_update();
    bit rdec, bdec;
    if (rst) begin
      model_reset();
      return;
    end
    rdec = rv && rr && rl;
    bdec = bv && br;
    if (mhs && !ms && !rdec) m_rd++;
    else if (rdec && !(mhs && !ms)) begin
      if (m_rd == 0) m_err = 1; else m_rd--;
    end
    if (mhs && ms && !bdec) m_wr++;
    else if (bdec && !(mhs && ms)) begin
      if (m_wr == 0) m_err = 1; else m_wr--;
    end
    if (m_mode == 0) begin
      if (fence || m_pend) begin
        if (mv && !rdy) m_pend = 1;
        else begin m_pend = 0; m_mode = 1; end
      end
    end else if (m_mode == 1) begin
      if (m_rd == 0 && m_wr == 0) m_mode = 2;
    end else begin
      m_mode = 0;
    end
    m_locked  = mv && !rdy;
    m_lock_st = ms;
    if (mhs) m_pref_st = !ms;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          l, s, r;
    logic [3:0]    exp_port;  // {issue_valid, is_store, ld_ready, st_ready}
    logic          exp_idle;
    logic [CW-1:0] exp_rd, exp_wr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int hs_cnt, done_cnt, done_cyc;
    logic [14:0] exp_vec, dut_vec;

    rst = 1;
    clear_inputs();
    tbl[0] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'd0, 4'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 4'b1010, 1'b0, 4'd1, 4'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 4'd0, 4'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 4'd1, 4'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 4'd0, 4'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 4'b1100, 1'b0, 4'd0, 4'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'd0, 4'd0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 4'd0, 4'd0};

    // reset state, with requests pending during reset
    tick();
    tick();
    ld = 1; st = 1; rdy = 1;
    settle();
    check("rst_issue_valid", 32'(iss_v_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    tick();
    rst = 0;
    clear_inputs();
    settle();
    check("rst_rd_cnt", 32'(rd_o), 32'd0);
    check("rst_wr_cnt", 32'(wr_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_idle", 32'(idle_o), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_req(tbl[i].l, tbl[i].s, tbl[i].r);
      settle();
      check($sformatf("tbl%0d_port", i), 32'({iss_v_o, iss_st_o, ld_rdy_o, st_rdy_o}),
            32'(tbl[i].exp_port));
      check($sformatf("tbl%0d_idle", i), 32'(idle_o), 32'(tbl[i].exp_idle));
      tick();
      check($sformatf("tbl%0d_cnts", i), 32'({rd_o, wr_o}), 32'({tbl[i].exp_rd, tbl[i].exp_wr}));
    end

    // alternation with both requesters always valid
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'(i % 2));
    for (int i = 0; i < 8; i++) begin
      set_req(1, 1, 1);
      settle();
      if (ld_rdy_o || st_rdy_o) begin
        if (exp_q.size() == 0) check("rr_extra_grant", 32'd1, 32'd0);
        else check($sformatf("rr_grant%0d", i), 32'(iss_st_o), 32'(exp_q.pop_front()));
      end
      tick();
    end
    check("rr_missing_grants", 32'(exp_q.size()), 32'd0);
    check("rr_cnts", 32'({rd_o, wr_o}), 32'({4'd4, 4'd4}));

    // load-only stream exhausting read credits
    do_reset();
    hs_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      set_req(1, 0, 1);
      settle();
      if (ld_rdy_o) hs_cnt++;
      tick();
    end
    check("credit_hs", 32'(hs_cnt), 32'd8);
    settle();
    check("credit_stall_valid", 32'(iss_v_o), 32'd0);
    r_beat(1);
    settle();
    check("credit_beat_no_grant", 32'(iss_v_o), 32'd0);
    tick();
    r_beat(0);
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (ld_rdy_o) hs_cnt++;
      tick();
    end
    check("credit_refill_hs", 32'(hs_cnt), 32'd1);
    check("credit_rd_cnt", 32'(rd_o), 32'd8);

    // grant lock while the address generator stalls
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(1, (i >= 1), 0);
      settle();
      check($sformatf("lock_valid%0d", i), 32'(iss_v_o), 32'd1);
      check($sformatf("lock_is_store%0d", i), 32'(iss_st_o), 32'd0);
      tick();
    end
    set_req(1, 1, 1);
    settle();
    check("lock_release_ld_ready", 32'({ld_rdy_o, st_rdy_o}), 32'b10);
    tick();
    check("lock_cnts", 32'({rd_o, wr_o}), 32'({4'd1, 4'd0}));

    // fence drain with rd=2, wr=1
    do_reset();
    for (int i = 0; i < 3; i++) begin set_req(1, 1, 1); tick(); end
    check("fence_setup_cnts", 32'({rd_o, wr_o}), 32'({4'd2, 4'd1}));
    clear_inputs();
    fence = 1;
    tick();
    fence = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      set_req(1, 1, 1);
      r_beat(c == 1 || c == 2);
      b_beat(c == 3);
      settle();
      if (done_o) begin done_cnt++; done_cyc = c; end
      if (c <= 4) check($sformatf("drain_no_grant%0d", c), 32'(iss_v_o), 32'd0);
      tick();
    end
    check("fence_done_count", 32'(done_cnt), 32'd1);
    check("fence_done_cycle", 32'(done_cyc), 32'd4);

    // fence sampled during a locked grant
    do_reset();
    set_req(1, 0, 0);
    fence = 1;
    tick();
    fence = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("fence_lock_hold%0d", i), 32'({iss_v_o, iss_st_o}), 32'b10);
      tick();
    end
    rdy = 1;
    settle();
    check("fence_lock_hs", 32'(ld_rdy_o), 32'd1);
    tick();
    r_beat(1);
    settle();
    check("fence_lock_drain", 32'(iss_v_o), 32'd0);
    tick();
    r_beat(0);
    settle();
    check("fence_lock_done", 32'(done_o), 32'd1);
    tick();

    // simultaneous increment/decrement and underflow
    do_reset();
    for (int i = 0; i < 3; i++) begin set_req(1, 0, 1); tick(); end
    set_req(1, 0, 1);
    r_beat(1);
    settle();
    check("sim_hs", 32'(ld_rdy_o), 32'd1);
    tick();
    check("sim_rd_cnt", 32'(rd_o), 32'd3);
    check("sim_err_clear", 32'(err_o), 32'd0);
    clear_inputs();
    b_beat(1);
    tick();
    b_beat(0);
    check("uflow_wr_cnt", 32'(wr_o), 32'd0);
    check("uflow_err", 32'(err_o), 32'd1);
    tick();
    check("uflow_err_sticky", 32'(err_o), 32'd1);

    // reset during drain
    do_reset();
    for (int i = 0; i < 5; i++) begin set_req(1, 0, 1); tick(); end
    clear_inputs();
    fence = 1;
    tick();
    fence = 0;
    tick();
    rst = 1;
    ld = 1;
    settle();
    check("drain_rst_valid", 32'(iss_v_o), 32'd0);
    check("drain_rst_done", 32'(done_o), 32'd0);
    tick();
    rst = 0;
    settle();
    check("drain_rst_cnts", 32'({rd_o, wr_o}), 32'd0);
    check("drain_rst_run", 32'(iss_v_o), 32'd1);
    ld = 0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (done_o) done_cnt++;
      tick();
    end
    check("drain_rst_no_done", 32'(done_cnt), 32'd0);
    check("drain_rst_idle", 32'(idle_o), 32'd1);

    // randomized run against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      ld    = ($urandom_range(0, 3) != 0);
      st    = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      rv    = 1'($urandom_range(0, 1));
      rr    = ($urandom_range(0, 3) != 0);
      rl    = 1'($urandom_range(0, 1));
      if (m_rd == 0 && $urandom_range(0, 63) != 0) rl = 0;
      bv    = 1'($urandom_range(0, 1));
      br    = ($urandom_range(0, 3) != 0);
      if (m_wr == 0 && $urandom_range(0, 63) != 0) bv = 0;
      fence = ($urandom_range(0, 39) == 0);
      settle();
      model_eval(exp_vec);
      dut_vec = {iss_v_o, iss_st_o, ld_rdy_o, st_rdy_o, idle_o, done_o, err_o, rd_o, wr_o};
      check($sformatf("rand_cycle%0d", i), 32'(dut_vec), 32'(exp_vec));
      model_update();
      tick();
    end
    clear_inputs();
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
